mp8_boot_loader: RTL and testbench

- Boot sequencer for the MP-8 processor.
- Holds the CPU in reset and owns the unified program/data memory write port while it streams a program image in over a valid/ready byte interface.
- Once the image is loaded, hands the memory back to the CPU and holds the CPU start line high.
- Sits between the external loader link, the memory and the MP-8 controller; supports reload after the CPU halts.

---
 rtl/mp8_boot_loader.sv | 153 +++++++++++++++
 tb/tb_mp8_boot_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mp8_boot_loader.sv
// MP-8 boot sequencer: holds the CPU in reset, streams a program image into memory, then releases the CPU.
// Optional feature macro MP8_BOOT_ZERO_FILL_EN zero-fills the words above the image before releasing the CPU.
module mp8_boot_loader #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_boot_req,
  input  logic          i_ld_valid,
  input  logic [DW-1:0] i_ld_data,
  input  logic          i_ld_last,
  output logic          o_ld_ready,
  input  logic          i_cpu_halted,
  input  logic [AW-1:0] i_cpu_mem_addr,
  input  logic [DW-1:0] i_cpu_mem_wdata,
  input  logic          i_cpu_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  output logic          o_cpu_reset,
  output logic          o_cpu_start,
  output logic [AW:0]   o_loaded_count,
  output logic          o_err_overflow,
  output logic          o_busy
);

  localparam int unsigned DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
`ifdef MP8_BOOT_ZERO_FILL_EN
    S_FILL  = 3'd2,
`endif
    S_START = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_loaded_count;
  logic          r_err_overflow;
  logic          w_xfer;
  logic          w_at_end;

  assign w_xfer   = (r_state == S_LOAD) && i_ld_valid;
  assign w_at_end = (r_addr == LAST_ADDR);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic; a byte landing on the top word always ends the image
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_boot_req) w_next = S_LOAD;
      S_LOAD: begin
        if (w_xfer && (i_ld_last || w_at_end)) begin
`ifdef MP8_BOOT_ZERO_FILL_EN
          w_next = w_at_end ? S_START : S_FILL;
`else
          w_next = S_START;
`endif
        end
      end
`ifdef MP8_BOOT_ZERO_FILL_EN
      S_FILL:  if (w_at_end) w_next = S_START;
`endif
      S_START: w_next = S_RUN;
      S_RUN:   if (i_boot_req && i_cpu_halted) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode and memory-port ownership mux
  always_comb begin
    o_ld_ready  = 1'b0;
    o_cpu_reset = 1'b1;
    o_cpu_start = 1'b0;
    o_busy      = 1'b1;
    o_mem_we    = 1'b0;
    o_mem_addr  = r_addr;
    o_mem_wdata = i_ld_data;
    case (r_state)
      S_LOAD: begin
        o_ld_ready = 1'b1;
        o_mem_we   = i_ld_valid;
      end
`ifdef MP8_BOOT_ZERO_FILL_EN
      S_FILL: begin
        o_mem_we    = 1'b1;
        o_mem_wdata = '0;
      end
`endif
      S_START: begin
        o_cpu_reset = 1'b0;
        o_mem_we    = i_cpu_mem_we;
        o_mem_addr  = i_cpu_mem_addr;
        o_mem_wdata = i_cpu_mem_wdata;
      end
      S_RUN: begin
        o_cpu_reset = 1'b0;
        o_cpu_start = 1'b1;
        o_busy      = 1'b0;
        o_mem_we    = i_cpu_mem_we;
        o_mem_addr  = i_cpu_mem_addr;
        o_mem_wdata = i_cpu_mem_wdata;
      end
      default: ;
    endcase
  end

  // Address counter, byte count and overflow flag; the counter never wraps
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_addr         <= '0;
      r_loaded_count <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_boot_req) begin
            r_addr         <= '0;
            r_loaded_count <= '0;
            r_err_overflow <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            if (!w_at_end)                  r_addr         <= r_addr + AW'(1);
            if (r_loaded_count != FULL_CNT) r_loaded_count <= r_loaded_count + (AW + 1)'(1);
            if (w_at_end && !i_ld_last)     r_err_overflow <= 1'b1;
          end
        end
`ifdef MP8_BOOT_ZERO_FILL_EN
        S_FILL: if (!w_at_end) r_addr <= r_addr + AW'(1);
`endif
        default: ;
      endcase
    end
  end

  assign o_loaded_count = r_loaded_count;
  assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_mp8_boot_loader.sv
// Self-checking bench for mp8_boot_loader: per-cycle behavioural model plus directed literal checks.
module tb_mp8_boot_loader;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset_n, boot_req, ld_valid, ld_last, cpu_halted, cpu_mem_we;
  logic [DW-1:0] ld_data, cpu_mem_wdata;
  logic [AW-1:0] cpu_mem_addr;
  logic          o_ld_ready, o_mem_we, o_cpu_reset, o_cpu_start, o_err_overflow, o_busy;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [AW:0]   o_loaded_count;

  mp8_boot_loader #(.AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_boot_req(boot_req),
    .i_ld_valid(ld_valid), .i_ld_data(ld_data), .i_ld_last(ld_last), .o_ld_ready(o_ld_ready),
    .i_cpu_halted(cpu_halted), .i_cpu_mem_addr(cpu_mem_addr), .i_cpu_mem_wdata(cpu_mem_wdata),
    .i_cpu_mem_we(cpu_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_we(o_mem_we), .o_cpu_reset(o_cpu_reset), .o_cpu_start(o_cpu_start),
    .o_loaded_count(o_loaded_count), .o_err_overflow(o_err_overflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory as seen through the DUT's write port
  logic [DW-1:0] sh_mem [DEPTH];
  always @(posedge clk) if (o_mem_we === 1'b1) sh_mem[o_mem_addr] <= o_mem_wdata;

  // Behavioural model of the boot sequence
  typedef enum int {P_IDLE, P_LOAD, P_FILL, P_START, P_RUN} ph_t;
  ph_t m_ph   = P_IDLE;
  int  m_ptr  = 0;
  int  m_cnt  = 0;
  bit  m_err  = 1'b0;
  bit  m_live = 1'b0;

  always @(posedge clk) begin
    m_live = 1'b1;
    if (!reset_n) begin
      m_ph = P_IDLE; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      case (m_ph)
        P_IDLE: if (boot_req) begin m_ph = P_LOAD; m_ptr = 0; m_cnt = 0; m_err = 1'b0; end
        P_LOAD: if (ld_valid) begin
          m_cnt = m_cnt + 1;
          if (m_ptr == DEPTH - 1) begin
            m_err = !ld_last;
            m_ph  = P_START;
          end else begin
            m_ptr = m_ptr + 1;
`ifdef MP8_BOOT_ZERO_FILL_EN
            if (ld_last) m_ph = P_FILL;
`else
            if (ld_last) m_ph = P_START;
`endif
          end
        end
        P_FILL: if (m_ptr == DEPTH - 1) m_ph = P_START; else m_ptr = m_ptr + 1;
        P_START: m_ph = P_RUN;
        P_RUN: if (boot_req && cpu_halted) m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    if (m_live) begin
      e_we = 1'b0; e_addr = '0; e_data = '0;
      case (m_ph)
        P_LOAD:        begin e_we = ld_valid;   e_addr = AW'(m_ptr);   e_data = ld_data;       end
        P_FILL:        begin e_we = 1'b1;       e_addr = AW'(m_ptr);   e_data = '0;            end
        P_START, P_RUN: begin e_we = cpu_mem_we; e_addr = cpu_mem_addr; e_data = cpu_mem_wdata; end
        default: ;
      endcase
      check("m_ld_ready",  32'(o_ld_ready),  32'(m_ph == P_LOAD));
      check("m_cpu_reset", 32'(o_cpu_reset), 32'(m_ph == P_IDLE || m_ph == P_LOAD || m_ph == P_FILL));
      check("m_cpu_start", 32'(o_cpu_start), 32'(m_ph == P_RUN));
      check("m_busy",      32'(o_busy),      32'(m_ph != P_RUN));
      check("m_count",     32'(o_loaded_count), 32'(m_cnt));
      check("m_err",       32'(o_err_overflow), 32'(m_err));
      check("m_mem_we",    32'(o_mem_we),    32'(e_we));
      if (e_we) begin
        check("m_mem_addr",  32'(o_mem_addr),  32'(e_addr));
        check("m_mem_wdata", 32'(o_mem_wdata), 32'(e_data));
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  // Zero-fill cycles that follow an image of n bytes when the feature is built in
  task automatic wait_fill(input int n);
`ifdef MP8_BOOT_ZERO_FILL_EN
    repeat (DEPTH - n) tick();
`else
    if (n < 0) tick();
`endif
  endtask

  task automatic reboot();
    boot_req = 1'b1; cpu_halted = 1'b1;
    tick();
    check("reboot_idle_cpu_reset", 32'(o_cpu_reset), 32'h1);
    check("reboot_idle_cpu_start", 32'(o_cpu_start), 32'h0);
    tick();
    boot_req = 1'b0; cpu_halted = 1'b0;
  endtask

  logic [DW-1:0] img [4];

  initial begin
    for (int i = 0; i < DEPTH; i++) sh_mem[i] = 8'h5A;
    reset_n = 1'b0; boot_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    cpu_halted = 1'b0; cpu_mem_we = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = '0;
    repeat (3) tick();
    check("rst_cpu_reset", 32'(o_cpu_reset), 32'h1);
    check("rst_busy",      32'(o_busy),      32'h1);
    check("rst_ld_ready",  32'(o_ld_ready),  32'h0);
    check("rst_count",     32'(o_loaded_count), 32'h0);
    check("rst_mem_we",    32'(o_mem_we),    32'h0);
    reset_n = 1'b1;
    tick();

    // Basic 4-byte load
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
    check("load_ready", 32'(o_ld_ready), 32'h1);
    img[0] = 8'h1F; img[1] = 8'h3E; img[2] = 8'hE8; img[3] = 8'hF0;
    for (int i = 0; i < 4; i++) send(img[i], i == 3);
    wait_fill(4);
    check("start_cpu_reset", 32'(o_cpu_reset), 32'h0);
    check("start_cpu_start", 32'(o_cpu_start), 32'h0);
    tick();
    check("run_cpu_start", 32'(o_cpu_start), 32'h1);
    check("run_count",     32'(o_loaded_count), 32'h4);
    check("run_err",       32'(o_err_overflow), 32'h0);
    check("mem0", 32'(sh_mem[0]), 32'h1F);
    check("mem1", 32'(sh_mem[1]), 32'h3E);
    check("mem2", 32'(sh_mem[2]), 32'hE8);
    check("mem3", 32'(sh_mem[3]), 32'hF0);

    // CPU pass-through in RUN
    cpu_mem_we = 1'b1; cpu_mem_addr = 5'h10; cpu_mem_wdata = 8'hAA;
    #1;
    check("pass_we",    32'(o_mem_we),    32'h1);
    check("pass_addr",  32'(o_mem_addr),  32'h10);
    check("pass_wdata", 32'(o_mem_wdata), 32'hAA);
    tick();
    cpu_mem_we = 1'b0;

    // boot_req without halt is ignored
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
    check("nohalt_run", 32'(o_cpu_start), 32'h1);

    // Reload with a 3-cycle stall, CPU write attempts ignored while loading
    reboot();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    cpu_mem_we = 1'b1; cpu_mem_addr = 5'h10; cpu_mem_wdata = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_mem_we", 32'(o_mem_we), 32'h0);
      tick();
    end
    cpu_mem_we = 1'b0;
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    wait_fill(4);
    tick();
    check("reload_count", 32'(o_loaded_count), 32'h4);
    check("reload_mem0",  32'(sh_mem[0]), 32'h11);
    check("reload_mem2",  32'(sh_mem[2]), 32'h33);
    check("reload_mem3",  32'(sh_mem[3]), 32'h44);

    // Overflow: 33 bytes offered, 32 accepted
    reboot();
    for (int i = 0; i < DEPTH; i++) send(8'(8'h80 + i), 1'b0);
    ld_valid = 1'b1; ld_data = 8'hA0;
    #1;
    check("ovf_ready",  32'(o_ld_ready),  32'h0);
    check("ovf_mem_we", 32'(o_mem_we),    32'h0);
    tick();
    ld_valid = 1'b0;
    check("ovf_count", 32'(o_loaded_count), 32'h20);
    check("ovf_err",   32'(o_err_overflow), 32'h1);
    check("ovf_mem31", 32'(sh_mem[31]), 32'h9F);
    check("ovf_mem0",  32'(sh_mem[0]),  32'h80);
    check("ovf_run",   32'(o_cpu_start), 32'h1);

`ifdef MP8_BOOT_ZERO_FILL_EN
    // Zero fill after a 2-byte image, then reset mid-fill
    reboot();
    send(8'h55, 1'b0);
    send(8'h66, 1'b1);
    repeat (30) tick();
    check("fill_start_reset", 32'(o_cpu_reset), 32'h0);
    check("fill_start_start", 32'(o_cpu_start), 32'h0);
    check("fill_mem1",  32'(sh_mem[1]),  32'h66);
    check("fill_mem2",  32'(sh_mem[2]),  32'h00);
    check("fill_mem16", 32'(sh_mem[16]), 32'h00);
    check("fill_mem31", 32'(sh_mem[31]), 32'h00);
    tick();
    reboot();
    send(8'h77, 1'b0);
    send(8'h88, 1'b1);
    repeat (5) tick();
    check("midfill_we", 32'(o_mem_we), 32'h1);
    reset_n = 1'b0;
    tick();
    check("midfill_rst_we",    32'(o_mem_we),    32'h0);
    check("midfill_rst_reset", 32'(o_cpu_reset), 32'h1);
    check("midfill_rst_ready", 32'(o_ld_ready),  32'h0);
    reset_n = 1'b1;
    tick();
`else
    // Reset from RUN clears status
    reset_n = 1'b0;
    tick();
    check("final_rst_reset", 32'(o_cpu_reset), 32'h1);
    check("final_rst_count", 32'(o_loaded_count), 32'h0);
    check("final_rst_err",   32'(o_err_overflow), 32'h0);
    reset_n = 1'b1;
    tick();
`endif
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
